vm2002_coin_acceptor: RTL and testbench

//  Upstream front end of the vm2002 vending FSM: accepts coins_t coins and accumulates credit.

---
 rtl/vm2002_coin_if.sv | 35 +++
 rtl/vm2002_coin_acceptor.sv | 162 ++++++++++++++++
 tb/tb_vm2002_coin_acceptor.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/vm2002_coin_if.sv
// Bus between the vm2002 coin acceptor (slave) and the vend controller / coin hardware (master).
// Coin codes on coin/change_coin: NICKEL=0, DIME=1, QUARTER=2, ILLEGALCOIN=3.
interface vm2002_coin_if #(
  parameter int CW = 8
);
  logic          coin_valid;
  logic [1:0]    coin;
  logic          cancel;
  logic          deduct_valid;
  logic [CW-1:0] deduct_amt;
  logic          deduct_ack;
  logic          deduct_nack;
  logic          coin_reject;
  logic [CW-1:0] credit;
  logic          change_valid;
  logic [1:0]    change_coin;
  logic          change_ready;
  logic          busy;
  logic          timed_out;
  logic [1:0]    state_dbg;

  // Change stream handshake: a coin transfers on every rising edge where change_valid and
  // change_ready are both 1; while change_ready is 0 the offered change_coin does not move.
  modport master (
    output coin_valid, coin, cancel, deduct_valid, deduct_amt, change_ready,
    input  deduct_ack, deduct_nack, coin_reject, credit, change_valid, change_coin,
    input  busy, timed_out, state_dbg
  );

  modport slave (
    input  coin_valid, coin, cancel, deduct_valid, deduct_amt, change_ready,
    output deduct_ack, deduct_nack, coin_reject, credit, change_valid, change_coin,
    output busy, timed_out, state_dbg
  );
endinterface

// File: rtl/vm2002_coin_acceptor.sv
// vm2002 coin acceptor: accumulates credit in nickel units, serves deducts, pays change greedily.
// Optional idle auto-refund is built when VM2002_COIN_TIMEOUT_EN is defined.
module vm2002_coin_acceptor #(
  parameter int CW             = 8,
  parameter int MAX_CREDIT     = 60,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic         clk,
  input  logic         rst_n,
  vm2002_coin_if.slave bus
);

  localparam logic [1:0] COIN_NICKEL  = 2'd0;
  localparam logic [1:0] COIN_DIME    = 2'd1;
  localparam logic [1:0] COIN_QUARTER = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CREDIT = 2'd1,
    S_CHANGE = 2'd2
  } state_t;

  if (MAX_CREDIT > (1 << CW) - 1 || MAX_CREDIT < 1 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("vm2002_coin_acceptor: MAX_CREDIT must fit in CW bits and TIMEOUT_CYCLES must be >= 2");
  end

  function automatic logic [CW-1:0] coin_value(input logic [1:0] c);
    case (c)
      COIN_NICKEL:  coin_value = CW'(1);
      COIN_DIME:    coin_value = CW'(2);
      COIN_QUARTER: coin_value = CW'(5);
      default:      coin_value = '0;
    endcase
  endfunction

  function automatic logic [1:0] greedy_coin(input logic [CW-1:0] c);
    if (c >= CW'(5))      greedy_coin = COIN_QUARTER;
    else if (c >= CW'(2)) greedy_coin = COIN_DIME;
    else                  greedy_coin = COIN_NICKEL;
  endfunction

  state_t        state_q, state_d;
  logic [CW-1:0] credit_q, credit_d;
  logic          ack_q, ack_d;
  logic          nack_q, nack_d;
  logic          reject_q, reject_d;
  logic          change_valid_q, change_valid_d;
  logic [1:0]    change_coin_q, change_coin_d;
  logic          busy_q, busy_d;
  logic          timed_out_q, timed_out_d;

  logic [CW-1:0] in_val;
  logic [CW:0]   coin_sum;
  logic          coin_fits;
  logic          coin_accepted;

`ifdef VM2002_COIN_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  logic [TW-1:0] tmo_q, tmo_d;
`endif

  always_comb begin
    in_val         = coin_value(bus.coin);
    coin_sum       = {1'b0, credit_q} + {1'b0, in_val};
    coin_fits      = (bus.coin != 2'd3) && (coin_sum <= (CW+1)'(MAX_CREDIT));
    state_d        = state_q;
    credit_d       = credit_q;
    ack_d          = 1'b0;
    nack_d         = 1'b0;
    reject_d       = 1'b0;
    timed_out_d    = 1'b0;
    coin_accepted  = 1'b0;

    // A deduct in the same cycle owns the credit register, so a concurrent coin bounces.
    if (bus.coin_valid) begin
      if (state_q != S_CHANGE && !bus.deduct_valid && coin_fits) begin
        credit_d      = coin_sum[CW-1:0];
        state_d       = S_CREDIT;
        coin_accepted = 1'b1;
      end else begin
        reject_d = 1'b1;
      end
    end

    if (bus.deduct_valid) begin
      if (state_q == S_CREDIT && bus.deduct_amt != '0 && credit_q >= bus.deduct_amt) begin
        ack_d    = 1'b1;
        credit_d = credit_q - bus.deduct_amt;
        state_d  = (credit_d == '0) ? S_IDLE : S_CHANGE;
      end else begin
        nack_d = 1'b1;
      end
    end

    if (bus.cancel && state_q == S_CREDIT && !ack_d) begin
      state_d = S_CHANGE;
    end

    if (state_q == S_CHANGE && bus.change_ready && change_valid_q) begin
      credit_d = credit_q - coin_value(change_coin_q);
      if (credit_d == '0) state_d = S_IDLE;
    end

`ifdef VM2002_COIN_TIMEOUT_EN
    if (state_q == S_CREDIT && state_d == S_CREDIT && !coin_accepted &&
        tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
      state_d     = S_CHANGE;
      timed_out_d = 1'b1;
    end
    tmo_d = (state_d != S_CREDIT || coin_accepted) ? '0 : tmo_q + TW'(1);
`endif

    change_valid_d = (state_d == S_CHANGE);
    change_coin_d  = (state_d == S_CHANGE) ? greedy_coin(credit_d) : COIN_NICKEL;
    busy_d         = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      credit_q       <= '0;
      ack_q          <= 1'b0;
      nack_q         <= 1'b0;
      reject_q       <= 1'b0;
      change_valid_q <= 1'b0;
      change_coin_q  <= 2'd0;
      busy_q         <= 1'b0;
      timed_out_q    <= 1'b0;
`ifdef VM2002_COIN_TIMEOUT_EN
      tmo_q          <= '0;
`endif
    end else begin
      state_q        <= state_d;
      credit_q       <= credit_d;
      ack_q          <= ack_d;
      nack_q         <= nack_d;
      reject_q       <= reject_d;
      change_valid_q <= change_valid_d;
      change_coin_q  <= change_coin_d;
      busy_q         <= busy_d;
      timed_out_q    <= timed_out_d;
`ifdef VM2002_COIN_TIMEOUT_EN
      tmo_q          <= tmo_d;
`endif
    end
  end

  assign bus.deduct_ack   = ack_q;
  assign bus.deduct_nack  = nack_q;
  assign bus.coin_reject  = reject_q;
  assign bus.credit       = credit_q;
  assign bus.change_valid = change_valid_q;
  assign bus.change_coin  = change_coin_q;
  assign bus.busy         = busy_q;
  assign bus.state_dbg    = state_q;
`ifdef VM2002_COIN_TIMEOUT_EN
  assign bus.timed_out    = timed_out_q;
`else
  assign bus.timed_out    = 1'b0;
`endif

endmodule

// File: tb/tb_vm2002_coin_acceptor.sv
// Self-checking bench for vm2002_coin_acceptor: directed credit/deduct/cancel/reset scenarios
// with a change-coin scoreboard fed when a refund is triggered and drained by a monitor.
module tb_vm2002_coin_acceptor;

  localparam int CW = 8;
  localparam logic [1:0] NICKEL  = 2'd0;
  localparam logic [1:0] DIME    = 2'd1;
  localparam logic [1:0] QUARTER = 2'd2;
  localparam logic [1:0] ILLEGAL = 2'd3;
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_CREDIT = 2'd1;
  localparam logic [1:0] ST_CHANGE = 2'd2;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  logic [1:0] exp_q[$];

  vm2002_coin_if #(.CW(CW)) bus ();

  vm2002_coin_acceptor #(.CW(CW), .MAX_CREDIT(60), .TIMEOUT_CYCLES(1024)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Inputs move 2 time units after a rising edge; the monitor looks at the falling edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic insert_coin(input logic [1:0] c, input logic exp_rej, input int exp_credit);
    bus.coin_valid = 1'b1;
    bus.coin       = c;
    step();
    bus.coin_valid = 1'b0;
    check("coin_reject", bus.coin_reject, exp_rej);
    check("coin_credit", bus.credit, exp_credit);
  endtask

  task automatic deduct(input int amt, input logic exp_ack, input int exp_credit);
    bus.deduct_valid = 1'b1;
    bus.deduct_amt   = CW'(amt);
    step();
    bus.deduct_valid = 1'b0;
    check("deduct_ack", bus.deduct_ack, exp_ack);
    check("deduct_nack", bus.deduct_nack, !exp_ack);
    check("deduct_credit", bus.credit, exp_credit);
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (!bus.busy) break;
      step();
    end
    check("idle_reached", bus.busy, 0);
    check("idle_credit", bus.credit, 0);
    check("idle_state", bus.state_dbg, ST_IDLE);
    check("chg_drained", exp_q.size(), 0);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst_n && bus.change_valid && bus.change_ready) begin
      if (exp_q.size() == 0) begin
        check("chg_unexpected", exp_q.size(), 1);
      end else begin
        check("chg_coin", bus.change_coin, exp_q.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic seen_tmo;
    int   k;
    n_checks = 0;
    n_fail   = 0;
    rst_n            = 1'b0;
    bus.coin_valid   = 1'b0;
    bus.coin         = NICKEL;
    bus.cancel       = 1'b0;
    bus.deduct_valid = 1'b0;
    bus.deduct_amt   = '0;
    bus.change_ready = 1'b1;
    do_reset();

    // reset state
    check("rst_credit", bus.credit, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_change_valid", bus.change_valid, 0);
    check("rst_state", bus.state_dbg, ST_IDLE);
    check("rst_pulses", {bus.deduct_ack, bus.deduct_nack, bus.coin_reject, bus.timed_out}, 0);

    // 1: accumulate
    insert_coin(QUARTER, 0, 5);
    check("t1_busy", bus.busy, 1);
    insert_coin(QUARTER, 0, 10);
    insert_coin(DIME, 0, 12);
    check("t1_state", bus.state_dbg, ST_CREDIT);

    // 2: deduct with remainder -> change DIME
    exp_q.push_back(DIME);
    deduct(10, 1, 2);
    check("t2_state", bus.state_dbg, ST_CHANGE);
    check("t2_change_valid", bus.change_valid, 1);
    wait_idle(20);
    step();
    check("t2_ack_one_cycle", bus.deduct_ack, 0);

    // 3: insufficient credit and zero price
    insert_coin(QUARTER, 0, 5);
    insert_coin(DIME, 0, 7);
    deduct(12, 0, 7);
    check("t3_state", bus.state_dbg, ST_CREDIT);
    deduct(0, 0, 7);

    // 4: fill to the ceiling, then overflow / illegal / coin-vs-deduct collisions
    for (int i = 0; i < 10; i++) insert_coin(QUARTER, 0, 12 + 5 * i);
    insert_coin(NICKEL, 0, 58);
    insert_coin(QUARTER, 1, 58);
    insert_coin(DIME, 0, 60);
    insert_coin(NICKEL, 1, 60);
    insert_coin(ILLEGAL, 1, 60);
    bus.coin_valid = 1'b1;
    bus.coin       = DIME;
    deduct(100, 0, 60);
    bus.coin_valid = 1'b0;
    check("t4_collide_reject", bus.coin_reject, 1);
    for (int i = 0; i < 12; i++) exp_q.push_back(QUARTER);
    bus.cancel = 1'b1;
    step();
    bus.cancel = 1'b0;
    check("t4_cancel_state", bus.state_dbg, ST_CHANGE);
    wait_idle(40);

    // 5: stalled refund of 8, coin refused during CHANGE
    insert_coin(QUARTER, 0, 5);
    insert_coin(DIME, 0, 7);
    insert_coin(NICKEL, 0, 8);
    bus.change_ready = 1'b0;
    bus.cancel = 1'b1;
    step();
    bus.cancel = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("t5_stall_valid", bus.change_valid, 1);
      check("t5_stall_coin", bus.change_coin, QUARTER);
      if (i == 1) insert_coin(DIME, 1, 8);
      else step();
    end
    check("t5_stall_credit", bus.credit, 8);
    exp_q.push_back(QUARTER);
    exp_q.push_back(DIME);
    exp_q.push_back(NICKEL);
    bus.change_ready = 1'b1;
    wait_idle(20);

    // deduct and cancel together: charge first, refund the remainder
    insert_coin(QUARTER, 0, 5);
    insert_coin(QUARTER, 0, 10);
    insert_coin(DIME, 0, 12);
    exp_q.push_back(QUARTER);
    exp_q.push_back(DIME);
    bus.cancel = 1'b1;
    deduct(5, 1, 7);
    bus.cancel = 1'b0;
    wait_idle(20);
    deduct(1, 0, 0);

    // 6: reset in the middle of a refund
    bus.change_ready = 1'b0;
    insert_coin(QUARTER, 0, 5);
    bus.cancel = 1'b1;
    step();
    bus.cancel = 1'b0;
    check("t6_in_change", bus.state_dbg, ST_CHANGE);
    rst_n = 1'b0;
    step();
    check("t6_rst_valid", bus.change_valid, 0);
    check("t6_rst_credit", bus.credit, 0);
    check("t6_rst_busy", bus.busy, 0);
    rst_n = 1'b1;
    bus.change_ready = 1'b1;

    // idle credit: held forever, or auto-refunded after 1024 cycles
    insert_coin(QUARTER, 0, 5);
    exp_q.push_back(QUARTER);
    seen_tmo = 1'b0;
    k = 0;
`ifdef VM2002_COIN_TIMEOUT_EN
    for (int i = 1; i <= 1100; i++) begin
      step();
      k = i;
      if (bus.timed_out) break;
    end
    check("tmo_pulse", bus.timed_out, 1);
    check("tmo_cycles", k, 1024);
    check("tmo_state", bus.state_dbg, ST_CHANGE);
`else
    for (int i = 0; i < 1100; i++) begin
      step();
      seen_tmo = seen_tmo | bus.timed_out;
      k = k + (bus.state_dbg == ST_CREDIT ? 1 : 0);
    end
    check("hold_no_timeout", seen_tmo, 0);
    check("hold_cycles_in_credit", k, 1100);
    check("hold_credit", bus.credit, 5);
    bus.cancel = 1'b1;
    step();
    bus.cancel = 1'b0;
`endif
    wait_idle(20);

    step();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
